// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type, limits and sanitize helper.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Out-of-range nibbles collapse to zero so a decoder never sees A-F.
    function automatic bcd_digit_t bcd_sanitize(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MIN : bcd_digit_t'(v);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one registered BCD digit cell with carry/borrow out.
// BCD_COUNTER_UPDOWN_EN adds the dir_i port and borrow path.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       step_i,
`ifdef BCD_COUNTER_UPDOWN_EN
    input  logic       dir_i,
`endif
    output bcd_digit_t digit_o,
    output logic       carry_o
);

    bcd_digit_t d_q, d_d;
    bcd_digit_t inc_val;

    assign inc_val = (d_q == BCD_MAX) ? BCD_MIN : d_q + 4'd1;

`ifdef BCD_COUNTER_UPDOWN_EN
    bcd_digit_t dec_val;
    assign dec_val = (d_q == BCD_MIN) ? BCD_MAX : d_q - 4'd1;
    // Ripple signal is a carry when counting up and a borrow when counting down.
    assign carry_o = step_i && (dir_i ? (d_q == BCD_MAX) : (d_q == BCD_MIN));
`else
    assign carry_o = step_i && (d_q == BCD_MAX);
`endif

    always_comb begin
        d_d = d_q;
        if (clr_i) begin
            d_d = BCD_MIN;
        end else if (load_i) begin
            d_d = bcd_sanitize(load_val_i);
        end else if (step_i) begin
`ifdef BCD_COUNTER_UPDOWN_EN
            d_d = dir_i ? inc_val : dec_val;
`else
            d_d = inc_val;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= BCD_MIN;
        end else begin
            d_q <= d_d;
        end
    end

    assign digit_o = d_q;

endmodule

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD counter with prescaler and wrap pulse.
// BCD_COUNTER_UPDOWN_EN enables the up_i port and down-counting.
module bcd_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [4*DIGITS-1:0] load_val_i,
`ifdef BCD_COUNTER_UPDOWN_EN
    input  logic                up_i,
`endif
    output logic [4*DIGITS-1:0] count_o,
    output logic                wrap_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          wrap_q, wrap_d;
    logic          tick;
    logic [DIGITS:0] step_chain;

    assign tick          = en_i && (pre_q == PRE_LAST);
    assign step_chain[0] = tick;

    always_comb begin
        pre_d = pre_q;
        if (clr_i || load_i) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = tick ? '0 : pre_q + PW'(1);
        end
    end

    // A tick coinciding with clear or load is discarded, so no wrap either.
    assign wrap_d = step_chain[DIGITS] && !clr_i && !load_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .clr_i      (clr_i),
            .load_i     (load_i),
            .load_val_i (load_val_i[4*i +: 4]),
            .step_i     (step_chain[i]),
`ifdef BCD_COUNTER_UPDOWN_EN
            .dir_i      (up_i),
`endif
            .digit_o    (count_o[4*i +: 4]),
            .carry_o    (step_chain[i+1])
        );
    end

    assign wrap_o = wrap_q;

endmodule
